// File: rtl/ddr3_gray_pkg.sv
// Shared constants, state type and geometry helper for the
// gray DDR3 frame writer/reader pair.
package ddr3_gray_pkg;

  localparam logic [26:0] BUF_STRIDE = 27'h20000;
  localparam int BUF_COUNT = 4;
  localparam int IMAGES_PER_FRAME = 4;
  localparam int WORD_BITS = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME_START,
    ST_CHECK_SPACE,
    ST_READ,
    ST_WRITE
  } state_t;

  function automatic int frame_num_bursts(
    input int fw,
    input int fl,
    input int ppr,
    input int bl
  );
    return fw * fl * IMAGES_PER_FRAME / (ppr * bl);
  endfunction

endpackage

// File: rtl/ddr3_reader_gray_out_if.sv
// Pointer strobe, Avalon-MM read master and pixel stream
// of the gray frame reader.
interface ddr3_reader_gray_out_if #(
  parameter int OUT_W = 16
);
  logic [1:0]     pointer_data;
  logic           pointer_valid;
  logic [26:0]    ddr3_read_address;
  logic           ddr3_read;
  logic [3:0]     ddr3_burstcount;
  logic           ddr3_waitrequest;
  logic [255:0]   ddr3_readdata;
  logic           ddr3_readdatavalid;
  logic [OUT_W:0] pixel_data;
  logic           pixel_valid;
  logic           pixel_ready;

  modport master (
    input  pointer_data, pointer_valid,
    input  ddr3_waitrequest, ddr3_readdata,
    input  ddr3_readdatavalid, pixel_ready,
    output ddr3_read_address, ddr3_read,
    output ddr3_burstcount, pixel_data, pixel_valid
  );

  modport slave (
    output pointer_data, pointer_valid,
    output ddr3_waitrequest, ddr3_readdata,
    output ddr3_readdatavalid, pixel_ready,
    input  ddr3_read_address, ddr3_read,
    input  ddr3_burstcount, pixel_data, pixel_valid
  );
endinterface

// File: rtl/ddr3_reader_fifo.sv
// Single-clock show-ahead FIFO for DDR3 read-return words.
// Head word is visible on rdata whenever not empty.
module ddr3_reader_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         rd,
  output logic [WIDTH-1:0]             rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   usedw
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_wr;
  logic             do_rd;

  assign empty = (usedw == '0);
  assign do_wr = wr && (usedw != CW'(DEPTH));
  assign do_rd = rd && !empty;
  assign rdata = mem[rp];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      usedw <= '0;
    end else begin
      if (do_wr)
        wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
      if (do_rd)
        rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + AW'(1);
      usedw <= usedw + CW'(do_wr) - CW'(do_rd);
    end
  end
endmodule

// File: rtl/ddr3_reader_gray_out.sv
// Reads completed gray frame buffers from DDR3 in bursts and
// unpacks each 256-bit word into a 16-bit pixel stream with SOF.
module ddr3_reader_gray_out #(
  parameter int out_width      = 16,
  parameter int rotate_buffers = 0,
  parameter int burst_len      = 8,
  parameter int frame_width    = 768,
  parameter int frame_lines    = 480,
  parameter int fifo_depth     = 64
) (
  input  logic                   ddr3_clk,
  input  logic                   ddr3clk_reset_n,
  input  logic [31:0]            start_address_i,
  ddr3_reader_gray_out_if.master bus
);
  import ddr3_gray_pkg::*;

  localparam int PPR = WORD_BITS / out_width;
  localparam int FNB =
    frame_num_bursts(frame_width, frame_lines, PPR, burst_len);
  localparam int BCW = (FNB > 1) ? $clog2(FNB) : 1;
  localparam int RWN = FNB * burst_len;
  localparam int RCW = (RWN > 1) ? $clog2(RWN) : 1;
  localparam int OCW = $clog2(fifo_depth + 1);
  localparam int PCW = (PPR > 1) ? $clog2(PPR) : 1;
  localparam int SBW = $clog2(BUF_COUNT);

  state_t           state;
  state_t           state_nx;
  logic [SBW-1:0]   ptr_q;
  logic [SBW-1:0]   ptr_now;
  logic [SBW-1:0]   buf_sel;
  logic             frame_avail;
  logic [26:0]      base_sel;
  logic [26:0]      addr_q;
  logic [BCW-1:0]   burst_counter;
  logic [OCW-1:0]   outstanding;
  logic [RCW-1:0]   ret_cnt;
  logic             accept;
  logic             ret_ok;
  logic             has_space;
  int               free_words;
  logic             fifo_empty;
  logic [OCW-1:0]   fifo_level;
  logic [WORD_BITS:0] fifo_q;
  logic [WORD_BITS-1:0] word_q;
  logic             sof_q;
  logic             valid_q;
  logic [PCW-1:0]   pix_idx;
  logic             xfer;
  logic             last_pix;
  logic             pop;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^start_address_i[4:0];

  // A pointer arriving in the FRAME_START cycle wins over ptr_q.
  assign ptr_now = bus.pointer_valid ? bus.pointer_data : ptr_q;
  assign buf_sel = (rotate_buffers != 0) ? ptr_now - SBW'(1) : '0;
  assign base_sel = start_address_i[31:5] + 27'(buf_sel) * BUF_STRIDE;

  always_ff @(posedge ddr3_clk) begin
    if (!ddr3clk_reset_n) begin
      ptr_q       <= (rotate_buffers != 0) ? SBW'(3) : '0;
      frame_avail <= 1'b0;
    end else if (bus.pointer_valid) begin
      ptr_q       <= bus.pointer_data;
      frame_avail <= 1'b1;
    end
  end

  assign free_words =
    fifo_depth - int'(fifo_level) - int'(outstanding);
  assign has_space = free_words >= burst_len;
  assign accept = (state == ST_READ) && !bus.ddr3_waitrequest;

  always_ff @(posedge ddr3_clk) begin
    if (!ddr3clk_reset_n) state <= ST_IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (frame_avail || bus.pointer_valid)
          state_nx = ST_FRAME_START;
      ST_FRAME_START: state_nx = ST_CHECK_SPACE;
      ST_CHECK_SPACE: if (has_space) state_nx = ST_READ;
      ST_READ:
        if (accept)
          state_nx = (burst_counter == BCW'(FNB - 1))
                   ? ST_FRAME_START : ST_CHECK_SPACE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ddr3_read         = (state == ST_READ);
    bus.ddr3_read_address = addr_q;
    bus.ddr3_burstcount   = 4'(burst_len);
  end

  always_ff @(posedge ddr3_clk) begin
    if (!ddr3clk_reset_n) begin
      addr_q        <= '0;
      burst_counter <= '0;
    end else if (state == ST_FRAME_START) begin
      addr_q        <= base_sel;
      burst_counter <= '0;
    end else if (accept) begin
      addr_q        <= addr_q + 27'(burst_len);
      burst_counter <= burst_counter + BCW'(1);
    end
  end

  // Returns with nothing outstanding are stray and dropped.
  assign ret_ok = bus.ddr3_readdatavalid && (outstanding != '0);

  always_ff @(posedge ddr3_clk) begin
    if (!ddr3clk_reset_n) begin
      outstanding <= '0;
      ret_cnt     <= '0;
    end else begin
      outstanding <= outstanding
                   + (accept ? OCW'(burst_len) : '0)
                   - OCW'(ret_ok);
      if (ret_ok)
        ret_cnt <= (ret_cnt == RCW'(RWN - 1)) ? '0 : ret_cnt + RCW'(1);
    end
  end

  ddr3_reader_fifo #(
    .WIDTH (WORD_BITS + 1),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk   (ddr3_clk),
    .rst_n (ddr3clk_reset_n),
    .wr    (ret_ok),
    .wdata ({ret_cnt == '0, bus.ddr3_readdata}),
    .rd    (pop),
    .rdata (fifo_q),
    .empty (fifo_empty),
    .usedw (fifo_level)
  );

  assign xfer     = valid_q && bus.pixel_ready;
  assign last_pix = (pix_idx == PCW'(PPR - 1));
  assign pop      = !fifo_empty && (!valid_q || (xfer && last_pix));

  always_ff @(posedge ddr3_clk) begin
    if (!ddr3clk_reset_n) begin
      word_q  <= '0;
      sof_q   <= 1'b0;
      valid_q <= 1'b0;
      pix_idx <= '0;
    end else if (pop) begin
      word_q  <= fifo_q[WORD_BITS-1:0];
      sof_q   <= fifo_q[WORD_BITS];
      valid_q <= 1'b1;
      pix_idx <= '0;
    end else if (xfer) begin
      if (last_pix) begin
        valid_q <= 1'b0;
      end else begin
        word_q  <= word_q >> out_width;
        sof_q   <= 1'b0;
        pix_idx <= pix_idx + PCW'(1);
      end
    end
  end

  assign bus.pixel_valid = valid_q;
  assign bus.pixel_data  = {sof_q, word_q[out_width-1:0]};
endmodule

// File: tb/tb_ddr3_reader_gray_out.sv
// Bench for the gray frame reader: table of pointer start vectors,
// random memory/backpressure run checked against a frame-level model.
module tb_ddr3_reader_gray_out;
  localparam int FW  = 32;
  localparam int FL  = 4;
  localparam int BL  = 8;
  localparam int DEP = 64;
  localparam int PPR = 16;
  localparam int FNB = FW * FL * 4 / (PPR * BL);

  typedef struct {
    logic [1:0]  ptr;
    logic [26:0] addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] start_addr = 32'h1000_0040;
  int total = 0;
  int bad = 0;

  int wr_mode = 2;
  int rdy_mode = 0;
  int gap_pct = 0;
  int pv_seq = 0;
  logic [1:0] pv_val = 2'd0;

  logic [1:0]  m_ptr;
  int          m_bidx;
  int          m_frames;
  logic [26:0] m_base;
  logic [26:0] ret_q[$];
  logic [16:0] exp_q[$];
  logic [26:0] frame_base[8];
  int n_acc = 0;
  int n_pix = 0;
  int n_pv_cyc = 0;

  ddr3_reader_gray_out_if #(.OUT_W(16)) bus();

  ddr3_reader_gray_out #(
    .out_width(16), .rotate_buffers(1), .burst_len(BL),
    .frame_width(FW), .frame_lines(FL), .fifo_depth(DEP)
  ) dut (
    .ddr3_clk(clk),
    .ddr3clk_reset_n(rst_n),
    .start_address_i(start_addr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] mem_word(input logic [26:0] a);
    logic [255:0] w;
    for (int j = 0; j < 8; j++)
      w[32*j +: 32] = {5'(j), a} ^ (32'h9e3779b9 * 32'(j + 1));
    return w;
  endfunction

  // Most recently completed buffer is the one before the pointer.
  function automatic logic [26:0] base_of(input logic [1:0] p);
    int b;
    b = (int'(p) + 3) % 4;
    return start_addr[31:5] + 27'(b * 32'h20000);
  endfunction

  // Memory, downstream sink and scoreboard, all driven at negedge.
  initial begin
    int pv_seen;
    logic [26:0] a;
    logic [255:0] wd;
    logic hold_prev;
    logic [16:0] held;
    pv_seen = 0;
    hold_prev = 1'b0;
    held = '0;
    m_ptr = 2'd3;
    m_bidx = 0;
    m_frames = 0;
    m_base = '0;
    bus.pointer_valid = 1'b0;
    bus.pointer_data = 2'd0;
    bus.ddr3_waitrequest = 1'b1;
    bus.ddr3_readdata = '0;
    bus.ddr3_readdatavalid = 1'b0;
    bus.pixel_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.pointer_valid = 1'b0;
      if (!rst_n) begin
        ret_q.delete();
        exp_q.delete();
        m_bidx = 0;
        m_frames = 0;
        m_ptr = 2'd3;
        hold_prev = 1'b0;
        bus.ddr3_readdatavalid = 1'b0;
        bus.ddr3_waitrequest = 1'b1;
        bus.pixel_ready = 1'b0;
      end else begin
        if (pv_seq != pv_seen) begin
          pv_seen = pv_seq;
          bus.pointer_valid = 1'b1;
          bus.pointer_data = pv_val;
          m_ptr = pv_val;
        end
        bus.ddr3_readdatavalid = 1'b0;
        if (ret_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
          bus.ddr3_readdatavalid = 1'b1;
          bus.ddr3_readdata = mem_word(ret_q.pop_front());
        end
        bus.ddr3_waitrequest = (wr_mode == 2) ||
          (wr_mode == 1 && $urandom_range(3) == 0);
        if (bus.ddr3_read && !bus.ddr3_waitrequest) begin
          if (m_bidx == 0) begin
            m_base = base_of(m_ptr);
            if (m_frames < 8) frame_base[m_frames] = m_base;
          end
          a = m_base + 27'(m_bidx * BL);
          chk("req_addr", 64'(bus.ddr3_read_address), 64'(a));
          for (int w = 0; w < BL; w++) begin
            ret_q.push_back(a + 27'(w));
            wd = mem_word(a + 27'(w));
            for (int k = 0; k < PPR; k++)
              exp_q.push_back({m_bidx == 0 && w == 0 && k == 0,
                               wd[16*k +: 16]});
          end
          n_acc++;
          m_bidx++;
          if (m_bidx == FNB) begin
            m_bidx = 0;
            m_frames++;
          end
        end
        bus.pixel_ready = (rdy_mode == 1) ||
          (rdy_mode == 2 && $urandom_range(9) < 7);
        if (hold_prev)
          chk("hold_stable", 64'(bus.pixel_data), 64'(held));
        if (bus.pixel_valid) n_pv_cyc++;
        if (bus.pixel_valid && bus.pixel_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pixel_extra: got %0h required none",
                     bus.pixel_data);
          end else begin
            chk("pixel", 64'(bus.pixel_data), 64'(exp_q.pop_front()));
          end
          n_pix++;
        end
        hold_prev = bus.pixel_valid && !bus.pixel_ready;
        held = bus.pixel_data;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_read", 64'(bus.ddr3_read), 64'(0));
    chk("rst_addr", 64'(bus.ddr3_read_address), 64'(0));
    chk("rst_pvalid", 64'(bus.pixel_valid), 64'(0));
    chk("rst_pdata", 64'(bus.pixel_data), 64'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl[4];
    logic [26:0] a0;
    logic [255:0] w0;
    int acc0;
    int pv0;
    int pix0;
    tbl[0].ptr = 2'd1; tbl[0].addr = 27'h0800002;
    tbl[1].ptr = 2'd2; tbl[1].addr = 27'h0820002;
    tbl[2].ptr = 2'd3; tbl[2].addr = 27'h0840002;
    tbl[3].ptr = 2'd0; tbl[3].addr = 27'h0860002;

    repeat (3) @(posedge clk);
    #1;
    chk("burstcount", 64'(bus.ddr3_burstcount), 64'(BL));
    rst_n = 1'b1;

    // First request: 3 cycles after the pointer, at the chosen base.
    wr_mode = 2;
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) begin
      do_reset();
      pv_val = tbl[i].ptr;
      pv_seq++;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("first_read_early", 64'(bus.ddr3_read), 64'(0));
      @(posedge clk); #1;
      chk("first_read", 64'(bus.ddr3_read), 64'(1));
      chk("first_addr", 64'(bus.ddr3_read_address), 64'(tbl[i].addr));
    end

    // Random run over several frames with a mid-frame pointer.
    do_reset();
    wr_mode = 1;
    rdy_mode = 2;
    gap_pct = 20;
    pv_val = 2'd1;
    pv_seq++;
    for (int t = 0; t < 5000 && !(m_frames == 1 && m_bidx == 2); t++)
      begin @(posedge clk); #1; end
    chk("wait_midframe", 64'(m_frames == 1 && m_bidx == 2), 64'(1));
    pv_val = 2'd2;
    pv_seq++;
    for (int t = 0; t < 20000 && m_frames < 3; t++)
      begin @(posedge clk); #1; end
    chk("wait_frames", 64'(m_frames >= 3), 64'(1));
    chk("frame0_base", 64'(frame_base[0]), 64'(27'h0800002));
    chk("frame1_base", 64'(frame_base[1]), 64'(27'h0800002));
    chk("frame2_base", 64'(frame_base[2]), 64'(27'h0820002));

    // Bus stall: request and address held, exactly one acceptance.
    rdy_mode = 1;
    gap_pct = 0;
    wr_mode = 2;
    for (int t = 0; t < 200 && !bus.ddr3_read; t++)
      begin @(posedge clk); #1; end
    chk("wait_read", 64'(bus.ddr3_read), 64'(1));
    a0 = bus.ddr3_read_address;
    acc0 = n_acc;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      chk("stall_read", 64'(bus.ddr3_read), 64'(1));
      chk("stall_addr", 64'(bus.ddr3_read_address), 64'(a0));
    end
    wr_mode = 0;
    @(posedge clk); #1;
    chk("stall_accepts", 64'(n_acc - acc0), 64'(1));
    chk("stall_read_drop", 64'(bus.ddr3_read), 64'(0));

    // Return-FIFO backpressure from a fresh frame.
    do_reset();
    wr_mode = 0;
    rdy_mode = 0;
    acc0 = n_acc;
    pv_val = 2'd1;
    pv_seq++;
    repeat (300) @(posedge clk);
    #1;
    chk("bp_bursts", 64'(n_acc - acc0), 64'(8));
    chk("bp_valid", 64'(bus.pixel_valid), 64'(1));
    w0 = mem_word(27'h0800002);
    chk("bp_first_pix", 64'(bus.pixel_data), 64'({1'b1, w0[15:0]}));
    rdy_mode = 1;
    repeat (400) @(posedge clk);
    #1;

    // Reset mid-frame, then silence until a new pointer.
    rdy_mode = 2;
    wr_mode = 1;
    gap_pct = 10;
    repeat (150) @(posedge clk);
    do_reset();
    pv0 = n_pv_cyc;
    acc0 = n_acc;
    repeat (100) @(posedge clk);
    #1;
    chk("post_rst_pixels", 64'(n_pv_cyc - pv0), 64'(0));
    chk("post_rst_reads", 64'(n_acc - acc0), 64'(0));
    pix0 = n_pix;
    pv_val = 2'd3;
    pv_seq++;
    for (int t = 0; t < 5000 && (n_pix - pix0) < 600; t++)
      begin @(posedge clk); #1; end
    chk("restart_pixels", 64'((n_pix - pix0) >= 600), 64'(1));
    chk("restart_base", 64'(frame_base[0]), 64'(27'h0840002));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
